// File: rtl/divider_unit.sv
// divider_unit: iterative restoring divider for the RV32M DIV/DIVU/REM/REMU ops.
// Produces one quotient bit per cycle on operand magnitudes, then applies the
// sign fix-up. With APPROXIMATE=1, DIV/DIVU may stop k iterations early and
// return a quotient whose low k bits are zero.
module divider_unit #(
  parameter int APPROXIMATE = 0
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic [6:0]  opcode,
  input  logic [6:0]  funct7,
  input  logic [2:0]  funct3,
  input  logic [7:0]  accuracy_level,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  output logic        div_unit_busy,
  output logic [31:0] div_output
);

  localparam int DATA_W = 32;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;
  localparam logic [DATA_W-1:0] INT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;

  // Two's-complement magnitude of an operand when it is treated as signed.
  function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] val,
                                                  input logic is_signed);
    return (is_signed && val[DATA_W-1]) ? -val : val;
  endfunction

  // Restores the sign of a magnitude result.
  function automatic logic [DATA_W-1:0] apply_sign(input logic [DATA_W-1:0] mag,
                                                   input logic neg);
    return neg ? -mag : mag;
  endfunction

  // Request decode
  logic              req_valid, req_signed, req_rem;
  logic              div_by_zero, overflow, special;
  logic [DATA_W-1:0] special_res;
  logic [4:0]        shift_req;
  logic              unused_acc;

  assign req_valid   = (opcode == OP_REG) && (funct7 == F7_MULDIV) && funct3[2];
  assign req_signed  = ~funct3[0];
  assign req_rem     = funct3[1];
  assign div_by_zero = (rs2 == '0);
  assign overflow    = req_signed && (rs1 == INT_MIN) && (rs2 == '1);
  assign special     = div_by_zero | overflow;
  assign special_res = div_by_zero ? (req_rem ? rs1 : '1)
                                   : (req_rem ? '0 : INT_MIN);
  // Only quotient ops may terminate early; remainders need every bit.
  assign shift_req   = ((APPROXIMATE != 0) && !req_rem) ? accuracy_level[4:0] : 5'd0;
  assign unused_acc  = ^accuracy_level[7:5];

  // Latched operation
  logic              op_rem_q, neg_quo_q, neg_rem_q;
  logic [4:0]        shift_q;
  logic [5:0]        cnt_q;
  logic [DATA_W-1:0] dvd_q, dvs_q, rem_q, quo_q;

  // One restoring step: shift in the next dividend bit, trial-subtract.
  logic [DATA_W:0]   rem_shift, trial;
  logic              bit_set, last_iter;
  logic [DATA_W-1:0] rem_next, quo_next, result;

  assign rem_shift = {rem_q, dvd_q[DATA_W-1]};
  assign trial     = rem_shift - {1'b0, dvs_q};
  assign bit_set   = ~trial[DATA_W];
  assign rem_next  = bit_set ? trial[DATA_W-1:0] : rem_shift[DATA_W-1:0];
  assign quo_next  = {quo_q[DATA_W-2:0], bit_set};
  assign last_iter = (cnt_q == (6'd31 - {1'b0, shift_q}));
  assign result    = op_rem_q ? apply_sign(rem_next, neg_rem_q)
                              : apply_sign(quo_next << shift_q, neg_quo_q);

  assign div_unit_busy = (state == CALC) || ((state == IDLE) && req_valid);

  // State register
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic: special operands bypass CALC; a withdrawn request aborts.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (req_valid) state_next = special ? DONE : CALC;
      CALC: begin
        if (!req_valid)     state_next = IDLE;
        else if (last_iter) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operand latch, iteration datapath and result register.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      op_rem_q   <= 1'b0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      shift_q    <= '0;
      cnt_q      <= '0;
      dvd_q      <= '0;
      dvs_q      <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      div_output <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            op_rem_q  <= req_rem;
            neg_quo_q <= req_signed & (rs1[DATA_W-1] ^ rs2[DATA_W-1]);
            neg_rem_q <= req_signed & rs1[DATA_W-1];
            shift_q   <= shift_req;
            cnt_q     <= '0;
            dvd_q     <= magnitude(rs1, req_signed);
            dvs_q     <= magnitude(rs2, req_signed);
            rem_q     <= '0;
            quo_q     <= '0;
            if (special) div_output <= special_res;
          end
        end
        CALC: begin
          if (req_valid) begin
            dvd_q <= dvd_q << 1;
            rem_q <= rem_next;
            quo_q <= quo_next;
            cnt_q <= cnt_q + 6'd1;
            if (last_iter) div_output <= result;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_divider_unit.sv
// Bench for divider_unit: exact and approximate instances share the inputs;
// directed cases plus randomized ops are compared with an arithmetic model.
module tb_divider_unit;

  logic        CLK = 1'b0;
  logic        reset;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [7:0]  accuracy_level;
  logic [31:0] rs1, rs2;
  logic        busy0, busy1;
  logic [31:0] out0, out1;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] last0 = '0;
  logic [31:0] last1 = '0;

  always #5 CLK = ~CLK;

  divider_unit #(.APPROXIMATE(0)) u_exact (
    .CLK(CLK), .reset(reset), .opcode(opcode), .funct7(funct7), .funct3(funct3),
    .accuracy_level(accuracy_level), .rs1(rs1), .rs2(rs2),
    .div_unit_busy(busy0), .div_output(out0)
  );

  divider_unit #(.APPROXIMATE(1)) u_approx (
    .CLK(CLK), .reset(reset), .opcode(opcode), .funct7(funct7), .funct3(funct3),
    .accuracy_level(accuracy_level), .rs1(rs1), .rs2(rs2),
    .div_unit_busy(busy1), .div_output(out1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Expected result and busy-cycle count from the arithmetic definition.
  function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] b, input int k,
                                             input bit approx, output int cyc);
    bit sgn, is_rem;
    int kk;
    logic [31:0] am, bm, q, r;
    sgn    = !f3[0];
    is_rem = f3[1];
    if (b == 0) begin
      cyc = 1;
      return is_rem ? a : 32'hFFFF_FFFF;
    end
    if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      cyc = 1;
      return is_rem ? 32'h0 : 32'h8000_0000;
    end
    am  = (sgn && a[31]) ? -a : a;
    bm  = (sgn && b[31]) ? -b : b;
    kk  = (approx && !is_rem) ? k : 0;
    cyc = 33 - kk;
    q   = ((am >> kk) / bm) << kk;
    r   = am % bm;
    if (is_rem) return (sgn && a[31]) ? -r : r;
    return (sgn && (a[31] ^ b[31])) ? -q : q;
  endfunction

  function automatic logic [31:0] pick_operand(input bit divisor);
    case ($urandom_range(0, 7))
      0:       return divisor ? 32'h0 : 32'h8000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'($urandom_range(1, 15));
      3:       return $urandom >> $urandom_range(0, 31);
      default: return $urandom;
    endcase
  endfunction

  task automatic drive_idle();
    opcode = '0; funct7 = '0; funct3 = '0;
    accuracy_level = '0; rs1 = '0; rs2 = '0;
  endtask

  task automatic set_req(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [7:0] acc);
    opcode = 7'b0110011; funct7 = 7'b0000001; funct3 = f3;
    rs1 = a; rs2 = b; accuracy_level = acc;
  endtask

  // Issue one request (called at a falling edge), count busy cycles per
  // instance and capture each output when its busy first drops.
  task automatic run(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                     input logic [7:0] acc, input bit scramble, input string tag);
    int ec0, ec1, c0, c1;
    bit d0, d1;
    logic [31:0] e0, e1, o0, o1;
    c0 = 0; c1 = 0; d0 = 0; d1 = 0; o0 = '0; o1 = '0;
    e0 = ref_result(f3, a, b, int'(acc[4:0]), 1'b0, ec0);
    e1 = ref_result(f3, a, b, int'(acc[4:0]), 1'b1, ec1);
    set_req(f3, a, b, acc);
    for (int cyc = 0; cyc < 80 && !(d0 && d1); cyc++) begin
      #1;
      if (!d0) begin
        if (busy0) c0++;
        else if (c0 > 0) begin d0 = 1; o0 = out0; end
      end
      if (!d1) begin
        if (busy1) c1++;
        else if (c1 > 0) begin d1 = 1; o1 = out1; end
      end
      if (d0 || d1) begin
        rs1 = a; rs2 = b;
      end else if (scramble && c0 > 1) begin
        rs1 = $urandom; rs2 = $urandom;
      end
      @(negedge CLK);
    end
    chk({tag, ":done"}, {30'd0, d0, d1}, 32'd3);
    chk({tag, ":cyc_exact"}, 32'(c0), 32'(ec0));
    chk({tag, ":out_exact"}, o0, e0);
    chk({tag, ":cyc_approx"}, 32'(c1), 32'(ec1));
    chk({tag, ":out_approx"}, o1, e1);
    last0 = e0;
    last1 = e1;
    drive_idle();
    repeat (2) @(negedge CLK);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    drive_idle();
    reset = 1'b0;
    repeat (2) @(negedge CLK);
    #1;
    chk("rst_out_exact", out0, 32'h0);
    chk("rst_out_approx", out1, 32'h0);
    chk("rst_busy_idle", {30'd0, busy0, busy1}, 32'd0);
    set_req(3'b101, 32'd100, 32'd7, 8'd0);
    #1;
    chk("rst_busy_req", {30'd0, busy0, busy1}, 32'd3);
    @(negedge CLK);
    #1;
    chk("rst_hold_out", out0, 32'h0);
    drive_idle();
    @(negedge CLK);
    reset = 1'b1;

    run(3'b101, 32'd100, 32'd7, 8'd0, 1'b0, "divu_100_7");
    run(3'b111, 32'd100, 32'd7, 8'd0, 1'b0, "remu_100_7");
    run(3'b100, 32'hFFFF_FFF9, 32'd2, 8'd0, 1'b0, "div_m7_2");
    run(3'b110, 32'hFFFF_FFF9, 32'd2, 8'd0, 1'b0, "rem_m7_2");
    run(3'b101, 32'h1234, 32'd0, 8'd0, 1'b0, "divu_by0");
    run(3'b111, 32'h1234, 32'd0, 8'd0, 1'b0, "remu_by0");
    run(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 8'd0, 1'b0, "div_ovf");
    run(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 8'd0, 1'b0, "rem_ovf");
    run(3'b101, 32'hFFFF_FFFF, 32'd1, 8'd4, 1'b0, "divu_approx4");
    run(3'b111, 32'hFFFF_FFFF, 32'd1, 8'd4, 1'b0, "remu_approx4");
    run(3'b100, 32'hFFFF_0123, 32'd3, 8'd7, 1'b1, "div_approx7_scr");

    // Multiply and plain ALU ops never make the unit busy.
    opcode = 7'b0110011; funct7 = 7'b0000001; funct3 = 3'b000; rs1 = 32'd5; rs2 = 32'd3;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("mul_busy", {30'd0, busy0, busy1}, 32'd0);
      @(negedge CLK);
    end
    funct7 = 7'b0000000; funct3 = 3'b100;
    #1;
    chk("xor_busy", {30'd0, busy0, busy1}, 32'd0);
    chk("xor_out", out0, last0);
    drive_idle();
    @(negedge CLK);

    // Withdrawn request mid-CALC: back to idle, output untouched.
    set_req(3'b101, 32'd1000, 32'd3, 8'd0);
    repeat (6) @(negedge CLK);
    drive_idle();
    @(negedge CLK);
    #1;
    chk("abort_busy", {30'd0, busy0, busy1}, 32'd0);
    chk("abort_out_exact", out0, last0);
    chk("abort_out_approx", out1, last1);
    @(negedge CLK);
    run(3'b101, 32'd1000, 32'd3, 8'd0, 1'b0, "after_abort");

    // Reset pulse mid-CALC discards the op; the request is then re-accepted.
    set_req(3'b101, 32'd20, 32'd4, 8'd0);
    repeat (11) @(negedge CLK);
    #2 reset = 1'b0;
    #1;
    chk("midrst_out_exact", out0, 32'h0);
    chk("midrst_out_approx", out1, 32'h0);
    chk("midrst_busy_req", {30'd0, busy0, busy1}, 32'd3);
    @(negedge CLK);
    reset = 1'b1;
    run(3'b101, 32'd20, 32'd4, 8'd0, 1'b0, "reissue_20_4");

    for (int i = 0; i < 40; i++) begin
      logic [2:0]  f3;
      logic [31:0] a, b;
      logic [7:0]  acc;
      f3  = 3'(3'd4 + 3'($urandom_range(0, 3)));
      a   = pick_operand(1'b0);
      b   = pick_operand(1'b1);
      acc = 8'($urandom);
      run(f3, a, b, acc, 1'($urandom_range(0, 1)), "rand");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/divider_unit.md
DIVIDER_UNIT -- requirements
Module: divider_unit

Interface
REQ-001 Parameter APPROXIMATE, default 0: 1 enables accuracy-controlled early termination of DIV/DIVU.
REQ-002 Port CLK  input  1  system clock; all state updates on rising edge.
REQ-003 Port reset  input  1  asynchronous, active-low; one clock domain only.
REQ-004 Port opcode  input  7  instruction opcode.
REQ-005 Port funct7  input  7  instruction funct7.
REQ-006 Port funct3  input  3  instruction funct3.
REQ-007 Port accuracy_level  input  8  approximation control; only bits [4:0] used.
REQ-008 Port rs1  input  32  dividend.
REQ-009 Port rs2  input  32  divisor.
REQ-010 Port div_unit_busy  output  1  high while a valid request has no result yet; core stalls.
REQ-011 Port div_output  output  32  quotient or remainder; valid when busy is low in DONE.

Function
REQ-012 Valid request SHALL be opcode=0110011, funct7=0000001, funct3[2]=1: 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-013 FSM states SHALL be IDLE, CALC, DONE; one-hot or binary encoding is an implementation choice.
REQ-014 IDLE + valid request at edge: latch rs1, rs2, funct3, k = accuracy_level[4:0]; go to CALC; otherwise stay IDLE.
REQ-015 CALC SHALL run a restoring radix-2 division on operand magnitudes, one quotient bit per cycle, MSB first.
REQ-016 Iteration count SHALL be 32, or 32-k when APPROXIMATE=1 and the op is DIV/DIVU; k=0 means exact.
REQ-017 Early-terminated quotient SHALL be shifted left by k with low k bits zero; REM/REMU always run 32 iterations.
REQ-018 After the final iteration the FSM SHALL enter DONE and register the sign-corrected result in div_output.
REQ-019 Signed fix-up: quotient negated when operand signs differ; remainder takes the sign of the dividend.
REQ-020 rs2=0: quotient = 0xFFFFFFFF (both DIV and DIVU); remainder = rs1; CALC skipped, IDLE goes directly to DONE.
REQ-021 DIV/REM with rs1=0x80000000, rs2=0xFFFFFFFF: quotient 0x80000000, remainder 0; CALC skipped.
REQ-022 div_unit_busy SHALL be combinational: high in IDLE with a valid request, high in CALC, low in DONE and otherwise.
REQ-023 Exact latency: request presented before edge 0 -> busy high for 33 cycles (edges 0..32), DONE from edge 33; special cases (REQ-020/021): busy 1 cycle.
REQ-024 DONE SHALL return to IDLE at the next edge unconditionally; div_output holds its value until the next result.
REQ-025 Valid request deasserted or changed to non-divide during CALC: abort, return to IDLE next edge, div_output unchanged.
REQ-026 Operand changes during CALC SHALL be ignored; only latched values are used.
REQ-027 Multiply and non-M opcodes SHALL never assert div_unit_busy.

Reset
REQ-028 reset low SHALL asynchronously force IDLE, div_output=0, iteration counter=0, internal registers=0.
REQ-029 Reset asserted mid-CALC SHALL discard the operation; after release the unit accepts a new request at the first edge.
REQ-030 During reset div_unit_busy SHALL still follow REQ-022 for a valid request held on the inputs.

Verification
REQ-031 DIVU rs1=100, rs2=7 -> busy high 33 cycles, div_output=14; REMU on the same operands -> 2.
REQ-032 DIV rs1=-7 (0xFFFFFFF9), rs2=2 -> 0xFFFFFFFD (-3); REM -> 0xFFFFFFFF (-1).
REQ-033 DIVU rs1=0x1234, rs2=0 -> 1-cycle busy, output 0xFFFFFFFF; REMU -> 0x1234; DIV 0x80000000/-1 -> 0x80000000.
REQ-034 APPROXIMATE=1, accuracy_level=4, DIVU 0xFFFFFFFF/1 -> busy 29 cycles, output 0xFFFFFFF0; REMU same operands -> 0, 33 cycles.
REQ-035 Reset pulsed low at cycle 10 of CALC -> output 0, IDLE; re-issued DIVU 20/4 -> 5 after 33 busy cycles.
REQ-036 Request withdrawn at cycle 5 of CALC -> IDLE next edge, busy low, div_output keeps prior value.
